// File: rtl/pwm_decoder_pkg.sv
// Definitions shared by the PWM generator, the decoder and their benches:
// default duty width, nominal period and lock FSM encodings.
package pwm_decoder_pkg;

  localparam int unsigned DC_W_DEF   = 4;
  localparam int unsigned PWM_PERIOD = 2 ** DC_W_DEF;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ACQ    = 2'd0;
  localparam fsm_state_t TRACK  = 2'd1;
  localparam fsm_state_t LOCKED = 2'd2;

  // Map a (DC_W+1)-bit high-sample count onto the DC_W-bit duty field;
  // a fully-high window saturates to all-ones.
  function automatic logic [7:0] sat_duty(input logic [8:0] raw, input int unsigned dc_w);
    logic [8:0] full_val;
    logic [8:0] ones;
    full_val = 9'd1 << dc_w;
    ones     = full_val - 9'd1;
    sat_duty = (raw == full_val) ? ones[7:0] : raw[7:0];
  endfunction

endpackage

// File: rtl/pwm_decoder_sync_edge.sv
// Two-flop synchronizer for an asynchronous input with a rising-edge strobe
// on the synchronized signal.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1;
  logic s2;
  logic s2_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s2_d;

endmodule

// File: rtl/pwm_decoder.sv
// PWM duty-cycle decoder: counts high samples over fixed 2**DC_W-clock windows,
// checks rising-edge spacing and tracks stability of successive readings.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int unsigned DC_W     = DC_W_DEF,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pwm_in,
  output logic [DC_W-1:0] duty_cycle,
  output logic            valid,
  output logic            full_high,
  output logic            locked,
  output logic            period_err
);

  localparam logic [DC_W-1:0] WIN_MAX  = '1;
  localparam logic [DC_W:0]   GAP_NOM  = {1'b1, {DC_W{1'b0}}};
  localparam logic [DC_W:0]   GAP_SAT  = '1;
  localparam logic [DC_W:0]   GAP_ONE  = {{DC_W{1'b0}}, 1'b1};
  localparam logic [2:0]      LOCK_TGT = 3'(LOCK_CNT);

  logic pwm_s;
  logic rise;

  sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pwm_in),
    .q     (pwm_s),
    .rise  (rise)
  );

  // Measurement window
  logic [DC_W-1:0] win_cnt;
  logic [DC_W:0]   acc;
  logic [DC_W:0]   raw;
  logic            win_end;
  logic            raw_full;
  logic [7:0]      duty_sat;

  assign win_end  = (win_cnt == WIN_MAX);
  assign raw      = acc + {{DC_W{1'b0}}, pwm_s};
  assign raw_full = raw[DC_W];

  always_comb begin
    duty_sat = sat_duty(9'(raw), DC_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt    <= '0;
      acc        <= '0;
      duty_cycle <= '0;
      full_high  <= 1'b0;
      valid      <= 1'b0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      valid   <= win_end;
      if (win_end) begin
        acc        <= '0;
        duty_cycle <= duty_sat[DC_W-1:0];
        full_high  <= raw_full;
      end else begin
        acc <= raw;
      end
    end
  end

  // Rising-edge spacing check; the first rise after reset only arms it
  logic [DC_W:0] gap_cnt;
  logic          seen_rise;
  logic          err_now;

  assign err_now = rise & seen_rise & (gap_cnt != GAP_NOM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt    <= '0;
      seen_rise  <= 1'b0;
      period_err <= 1'b0;
    end else begin
      period_err <= err_now;
      if (rise) begin
        gap_cnt   <= GAP_ONE;
        seen_rise <= 1'b1;
      end else if (gap_cnt != GAP_SAT) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  // Lock FSM; a spacing error overrides a reading landing in the same cycle
  fsm_state_t state;
  fsm_state_t state_nxt;
  logic [DC_W:0] ref_raw;
  logic [DC_W:0] ref_nxt;
  logic [2:0]    match_cnt;
  logic [2:0]    match_nxt;
  logic [2:0]    match_inc;

  assign match_inc = match_cnt + 3'd1;

  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_raw;
    match_nxt = match_cnt;
    if (err_now) begin
      state_nxt = ACQ;
      match_nxt = '0;
    end else if (win_end) begin
      unique case (state)
        ACQ: begin
          state_nxt = TRACK;
          ref_nxt   = raw;
          match_nxt = '0;
        end
        TRACK: begin
          if (raw == ref_raw) begin
            match_nxt = match_inc;
            if (match_inc == LOCK_TGT) state_nxt = LOCKED;
          end else begin
            ref_nxt   = raw;
            match_nxt = '0;
          end
        end
        LOCKED: begin
          if (raw != ref_raw) begin
            state_nxt = TRACK;
            ref_nxt   = raw;
            match_nxt = '0;
          end
        end
        default: begin
          state_nxt = ACQ;
          match_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACQ;
      ref_raw   <= '0;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ref_raw   <= ref_nxt;
      match_cnt <= match_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule
